rr_grant_scheduler: RTL and testbench

- Round-robin scheduler that shares one downstream resource among N_REQ requesters.
- Grants exclusive, lockable ownership and enforces a bounded hold time.
- Sits between requester agents and the shared resource; drives the resource-side select index and the valid strobe.
- Fairness pointer, grant FSM and hold-timeout counter are all registered.

---
 rtl/rr_sched_pkg.sv | 55 +++++
 rtl/rr_priority_pick.sv | 21 ++
 rtl/rr_grant_scheduler.sv | 105 ++++++++++
 tb/tb_rr_grant_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler and its picker.
// rr_pick works on a fixed 32-bit view so one implementation serves any N_REQ up to 32.
package rr_sched_pkg;

    localparam int unsigned MAX_REQ = 32;
    localparam int unsigned PTR_W   = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_hold);
        return (max_hold == 0) ? 8 : $clog2(max_hold + 1);
    endfunction

    // Rotate req so ptr lands at bit 0, find the lowest set bit, then map back.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PTR_W-1:0]   ptr,
                                      input int unsigned        n);
        pick_t              res;
        logic [MAX_REQ-1:0] rot;
        int unsigned        src;
        int unsigned        first;
        res   = '0;
        rot   = '0;
        first = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            src = 32'(ptr) + i;
            if (src >= n) src = src - n;
            if (i < n) rot[i] = req[src[PTR_W-1:0]];
        end
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                res.found = 1'b1;
                first     = unsigned'(i);
            end
        end
        src = 32'(ptr) + first;
        if (src >= n) src = src - n;
        res.idx = src[PTR_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_pick
    import rr_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        pick_t res;
        res   = rr_pick(MAX_REQ'(req), PTR_W'(ptr), N_REQ);
        idx   = IDX_W'(res.idx);
        found = res.found;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler granting one shared resource with lockable ownership,
// a bounded hold time and a fixed idle gap after each release.
//
// state    | meaning
// IDLE     | no owner; picks from the pointer and grants on the next edge
// GRANT    | one requester owns the resource; hold counter running
// COOLDOWN | forced idle gap of COOLDOWN_CYC cycles before IDLE
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter  int unsigned N_REQ        = 4,
    parameter  int unsigned MAX_HOLD     = 16,
    parameter  int unsigned COOLDOWN_CYC = 1,
    localparam int unsigned IDX_W        = idx_width(N_REQ),
    localparam int unsigned CNT_W        = cnt_width(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

    sched_state_e     state;
    logic [IDX_W-1:0] ptr;
    logic [2:0]       cd_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             holder_release;
    logic             hold_limit;
    logic [IDX_W-1:0] next_ptr;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // grant_idx_o is only meaningful as the holder while in GRANT.
    assign holder_release = done_i[grant_idx_o] || !req_i[grant_idx_o];
    assign hold_limit     = (MAX_HOLD != 0) && (hold_cnt_o == CNT_W'(HOLD_LAST));
    assign next_ptr       = (grant_idx_o == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    assign grant_valid_o  = |grant_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cd_cnt      <= '0;
            grant_o     <= '0;
            grant_idx_o <= '0;
            hold_cnt_o  <= '0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        grant_o     <= ONE_HOT_0 << pick_idx;
                        grant_idx_o <= pick_idx;
                        hold_cnt_o  <= '0;
                    end
                end
                GRANT: begin
                    if (holder_release || hold_limit) begin
                        state       <= COOLDOWN;
                        grant_o     <= '0;
                        grant_idx_o <= '0;
                        hold_cnt_o  <= '0;
                        ptr         <= next_ptr;
                        cd_cnt      <= 3'(COOLDOWN_CYC - 1);
                        // A release that coincides with the limit is not a revocation.
                        timeout_o   <= !holder_release;
                    end else if (hold_cnt_o != '1) begin
                        hold_cnt_o <= hold_cnt_o + CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench: hand vectors, corner sequences and random traffic vs a reference model.
module tb_rr_grant_scheduler;

    localparam int N_REQ        = 4;
    localparam int MAX_HOLD     = 4;
    localparam int COOLDOWN_CYC = 1;
    localparam int IDX_W        = $clog2(N_REQ);
    localparam int CNT_W        = (MAX_HOLD == 0) ? 8 : $clog2(MAX_HOLD + 1);
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] done_i;
    logic [N_REQ-1:0] grant_o;
    logic             grant_valid_o;
    logic [IDX_W-1:0] grant_idx_o;
    logic [CNT_W-1:0] hold_cnt_o;
    logic             timeout_o;

    int checks   = 0;
    int failures = 0;

    rr_grant_scheduler #(
        .N_REQ        (N_REQ),
        .MAX_HOLD     (MAX_HOLD),
        .COOLDOWN_CYC (COOLDOWN_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .done_i        (done_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_idx_o   (grant_idx_o),
        .hold_cnt_o    (hold_cnt_o),
        .timeout_o     (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Reference model: owner (-1 = none), cycles held, fairness pointer, edges left before a pick.
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_wait;
    bit m_to;

    task automatic model_update();
        bit rel;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            m_wait  = 0;
        end else if (m_owner >= 0) begin
            rel = !req_i[m_owner] || done_i[m_owner];
            if (rel || (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1)) begin
                m_to    = !rel;
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
                m_cnt   = 0;
                m_wait  = COOLDOWN_CYC;
            end else if (m_cnt < CNT_MAX) begin
                m_cnt++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                int j;
                j = (m_ptr + k) % N_REQ;
                if (req_i[j]) begin
                    m_owner = j;
                    m_cnt   = 0;
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [N_REQ-1:0] exp_grant;
        @(posedge clk);
        model_update();
        #1;
        exp_grant = (m_owner >= 0) ? N_REQ'(1) << m_owner : '0;
        chk("model_grant",   32'(grant_o),       32'(exp_grant));
        chk("model_valid",   32'(grant_valid_o), 32'(m_owner >= 0));
        chk("model_idx",     32'(grant_idx_o),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("model_cnt",     32'(hold_cnt_o),    32'(m_cnt));
        chk("model_timeout", 32'(timeout_o),     32'(m_to));
    endtask

    typedef struct {
        logic             rst;
        logic [N_REQ-1:0] req;
        logic [N_REQ-1:0] done;
        logic [N_REQ-1:0] grant;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
        logic             to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input logic [3:0] g, input int idx, input int cnt, input logic to);
        vec_t v;
        v.rst   = r;
        v.req   = rq;
        v.done  = dn;
        v.grant = g;
        v.idx   = IDX_W'(idx);
        v.cnt   = CNT_W'(cnt);
        v.to    = to;
        vecs.push_back(v);
    endtask

    initial begin
        rst    = 1'b1;
        req_i  = '0;
        done_i = '0;

        //   rst  req      done     grant    idx cnt to
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);  // reset state
        add(0, 4'b0100, 4'b0000, 4'b0100, 2, 0, 0);  // 1-cycle grant latency
        add(0, 4'b0100, 4'b0001, 4'b0100, 2, 1, 0);  // non-holder done ignored
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0);  // holder done -> release
        add(0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0);  // cooldown
        add(0, 4'b0100, 4'b0000, 4'b0100, 2, 0, 0);  // regrant after idle
        add(0, 4'b0101, 4'b0000, 4'b0100, 2, 1, 0);  // no preemption by req0
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0);  // req drop -> release, ptr 3
        add(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 4'b1000, 3, 0, 0);  // pointer at 3 picks 3 over 0
        add(0, 4'b1001, 4'b0000, 4'b1000, 3, 1, 0);
        add(0, 4'b1001, 4'b1000, 4'b0000, 0, 0, 0);  // release, ptr wraps to 0
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0);
        add(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0);
        add(0, 4'b0011, 4'b0000, 4'b0001, 0, 2, 0);
        add(0, 4'b0011, 4'b0000, 4'b0001, 0, 3, 0);
        add(0, 4'b0011, 4'b0000, 4'b0000, 0, 0, 1);  // timeout pulse
        add(0, 4'b0011, 4'b0000, 4'b0000, 0, 0, 0);  // pulse lasts one cycle
        add(0, 4'b0011, 4'b0000, 4'b0010, 1, 0, 0);  // pointer advanced to 1
        add(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 1, 2, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 1, 3, 0);
        add(0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0);  // release at limit: no timeout
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            req_i  = vecs[i].req;
            done_i = vecs[i].done;
            step();
            chk($sformatf("vec%0d_grant", i),   32'(grant_o),       32'(vecs[i].grant));
            chk($sformatf("vec%0d_valid", i),   32'(grant_valid_o), 32'(vecs[i].grant != 0));
            chk($sformatf("vec%0d_idx", i),     32'(grant_idx_o),   32'(vecs[i].idx));
            chk($sformatf("vec%0d_cnt", i),     32'(hold_cnt_o),    32'(vecs[i].cnt));
            chk($sformatf("vec%0d_timeout", i), 32'(timeout_o),     32'(vecs[i].to));
        end

        // Fairness: all request, each holder releases after two cycles.
        rst = 1'b1; req_i = '0; done_i = '0;
        step();
        rst = 1'b0; req_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int waited;
            waited = 0;
            while (!grant_valid_o && waited < 8) begin
                step();
                waited++;
            end
            chk("fair_valid", 32'(grant_valid_o), 32'd1);
            chk("fair_order", 32'(grant_idx_o), 32'(g % N_REQ));
            step();
            done_i = N_REQ'(1) << (g % N_REQ);
            step();
            done_i = '0;
        end

        // Timeout on requester 1, then requester 2 is next in line.
        rst = 1'b1; req_i = '0;
        step();
        rst = 1'b0; req_i = 4'b0010;
        step();
        chk("to_grant", 32'(grant_o), 32'b0010);
        req_i = 4'b0110;
        for (int c = 1; c < MAX_HOLD; c++) begin
            step();
            chk("to_cnt", 32'(hold_cnt_o), 32'(c));
        end
        step();
        chk("to_revoke", 32'(grant_o), 32'd0);
        chk("to_pulse", 32'(timeout_o), 32'd1);
        step();
        chk("to_pulse_end", 32'(timeout_o), 32'd0);
        step();
        chk("to_next_idx", 32'(grant_idx_o), 32'd2);

        // Reset mid-grant on index 3, then pointer is back at 0.
        rst = 1'b1; req_i = '0;
        step();
        rst = 1'b0; req_i = 4'b1000;
        step();
        chk("rst_pre_idx", 32'(grant_idx_o), 32'd3);
        step();
        rst = 1'b1;
        step();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_cnt", 32'(hold_cnt_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst = 1'b0; req_i = 4'b1010;
        step();
        chk("rst_post_idx", 32'(grant_idx_o), 32'd1);

        // Random traffic: sticky request levels, occasional done bursts and resets.
        rst = 1'b1; req_i = '0; done_i = '0;
        step();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [N_REQ-1:0] flip;
            for (int b = 0; b < N_REQ; b++) flip[b] = ($urandom_range(0, 5) == 0);
            req_i  = req_i ^ flip;
            done_i = ($urandom_range(0, 3) == 0) ? N_REQ'($urandom) : '0;
            rst    = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
